alu_md: RTL
===========

Name: alu_md

Overview:
- Parametrised next-generation ALU for the MIPS core: all single-cycle ALU operations plus an iterative multiply/divide unit with architectural HI/LO registers.
- Sits in EX. Takes operands via a valid/ready handshake and returns a registered result with a one-cycle out_valid pulse.
- Simple ops complete in 1 cycle. MULT/MULTU/DIV/DIVU take WIDTH+1 cycles; during that time the block deasserts in_ready so the pipeline stalls.

Parameters:
- WIDTH, 32, datapath width in bits; even, >=8.
- SHW, $clog2(WIDTH), shift-amount width (derived; do not override).

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, op/a/b/shamt valid this cycle.
- in_ready, output, 1, block can accept; equals (state==IDLE).
- op, input, 5, operation code (see Behaviour).
- a, input, WIDTH, operand A (rs).
- b, input, WIDTH, operand B (rt or extended immediate).
- shamt, input, SHW, shift amount.
- out_valid, output, 1, one-cycle pulse: result/zero/overflow valid.
- result, output, WIDTH, registered result.
- zero, output, 1, registered (result==0).
- overflow, output, 1, registered signed overflow for ADD/SUB; 0 for all other ops.
- hi, output, WIDTH, HI register (debug/forwarding visibility).
- lo, output, WIDTH, LO register.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; result, hi, lo, counter and internal regs =0; out_valid=0; overflow=0. zero=1 (result is 0). Reset during MUL/DIV aborts the operation and discards all partial state.
- Accept only when in_valid && in_ready at a rising edge. in_valid is ignored when in_ready=0; it is never queued.
- Opcodes and results:
  - 0 ADD: a+b.
  - 1 SUB: a-b.
  - 2 OR, 3 AND.
  - 4 SLT: signed compare. 9 SLTU: unsigned compare.
  - 5 NOR.
  - 6 SRL: b>>shamt, logical. 11 SLL: b<<shamt. 12 SRA: arithmetic b>>>shamt.
  - 7 PASSB: result=b (LUI; operand already shifted).
  - 8 EQ: (a==b).
  - 10 XOR.
  - 13 MULT, 14 MULTU, 15 DIV, 16 DIVU.
  - 17 MFHI: result=hi. 18 MFLO: result=lo.
  - 19 MTHI: hi<=a, result=a. 20 MTLO: lo<=a, result=a.
  - 21-31: result=0, no HI/LO change.
- Arithmetic wraps modulo 2^WIDTH.
- overflow is set for ADD when the operand signs are equal and the result sign differs; for SUB when the operand signs differ and the result sign differs from a. No trap.
- Simple ops (everything except 13-16): result/zero/overflow registered at the accept edge. out_valid=1 for exactly the next cycle. Latency 1. Back-to-back accepts allowed every cycle.
- FSM states:
  - IDLE: accept. Ops 13/14 go to MUL, ops 15/16 go to DIV, others stay in IDLE.
  - MUL: shift-add, one bit per cycle, WIDTH cycles (counter WIDTH-1 down to 0), then FIX.
  - DIV: restoring division, one quotient bit per cycle, WIDTH cycles, then FIX.
  - FIX: apply signs, write {hi,lo}, result=lo, out_valid=1, go to IDLE.
- Mul/div latency: out_valid is high in cycle WIDTH+1 after the accept edge. in_ready=1 again in that same cycle.
- Signed ops: operate on magnitudes, then fix up in FIX.
  - Product is negated if the operand signs differ.
  - Quotient truncates toward zero.
  - Remainder takes the sign of the dividend.
- MULT/MULTU: {hi,lo} = full 2*WIDTH-bit product.
- DIV/DIVU: lo=quotient, hi=remainder.
- Divide by zero (b==0, signed or unsigned): lo = all ones, hi = a. Full latency still applies.
- Signed MIN/-1: lo=MIN, hi=0 (no special flag).
- HI/LO change only in FIX and on MTHI/MTLO. A MFHI accepted the cycle after FIX sees the new value.
- During MUL/DIV, result, zero and overflow hold their previous values and out_valid=0.

Decomposition:
- Package alu_md_pkg:
  - opcode localparams (OP_ADD..OP_MTLO),
  - FSM state encoding (IDLE, MUL, DIV, FIX),
  - a function for signed add/sub overflow.
- Sub-module md_iter: iterative multiply/divide datapath.
  - Contents: operand magnitude regs, accumulator, counter, sign fixup.
  - Interface: start, is_div, is_signed, a, b → done, hi_out, lo_out.
  - alu_md owns the FSM-visible handshake, the simple-op datapath and the HI/LO registers.

Test Plan (WIDTH=32):
- Reset then ADD a=0x7FFFFFFF b=1 → 1 cycle later out_valid=1, result=0x80000000, overflow=1, zero=0. Then SUB a=5 b=5 → result=0, zero=1, overflow=0.
- Shifts with b=0x80000000, shamt=4: SRL→0x08000000, SRA→0xF8000000, SLL→0. SLT a=-1 b=1 → 1; SLTU same operands → 0.
- MULT a=-3 b=7 → in_ready=0 for 32 cycles, out_valid at cycle 33, {hi,lo}=0xFFFFFFFF_FFFFFFEB. MFHI next cycle → 0xFFFFFFFF. MULTU 0xFFFFFFFF×0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- DIV a=-7 b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/0 → lo=0xFFFFFFFF, hi=7. DIV 0x80000000/-1 → lo=0x80000000, hi=0.
- Hold in_valid high with ADD while busy in DIV → no extra out_valid pulses. The ADD is accepted in the cycle in_ready returns, and its result follows 1 cycle later.
- Assert rst_n=0 mid-MULT (cycle 10) → immediately in_ready=1, out_valid=0, hi=lo=0, result=0. MFLO after release → 0.

Source files
------------

// File: rtl/alu_md_pkg.sv
// Shared opcodes, FSM encoding and overflow helper for the alu_md
// execute-stage ALU.
package alu_md_pkg;

    localparam int OP_W = 5;

    localparam logic [OP_W-1:0] OP_ADD   = 5'd0;
    localparam logic [OP_W-1:0] OP_SUB   = 5'd1;
    localparam logic [OP_W-1:0] OP_OR    = 5'd2;
    localparam logic [OP_W-1:0] OP_AND   = 5'd3;
    localparam logic [OP_W-1:0] OP_SLT   = 5'd4;
    localparam logic [OP_W-1:0] OP_NOR   = 5'd5;
    localparam logic [OP_W-1:0] OP_SRL   = 5'd6;
    localparam logic [OP_W-1:0] OP_PASSB = 5'd7;
    localparam logic [OP_W-1:0] OP_EQ    = 5'd8;
    localparam logic [OP_W-1:0] OP_SLTU  = 5'd9;
    localparam logic [OP_W-1:0] OP_XOR   = 5'd10;
    localparam logic [OP_W-1:0] OP_SLL   = 5'd11;
    localparam logic [OP_W-1:0] OP_SRA   = 5'd12;
    localparam logic [OP_W-1:0] OP_MULT  = 5'd13;
    localparam logic [OP_W-1:0] OP_MULTU = 5'd14;
    localparam logic [OP_W-1:0] OP_DIV   = 5'd15;
    localparam logic [OP_W-1:0] OP_DIVU  = 5'd16;
    localparam logic [OP_W-1:0] OP_MFHI  = 5'd17;
    localparam logic [OP_W-1:0] OP_MFLO  = 5'd18;
    localparam logic [OP_W-1:0] OP_MTHI  = 5'd19;
    localparam logic [OP_W-1:0] OP_MTLO  = 5'd20;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } state_t;

    // Two's-complement overflow from sign bits only; sub=1 means a-b.
    function automatic logic addsub_ovf(input logic sub, input logic a_msb,
                                        input logic b_msb, input logic r_msb);
        if (sub)
            return (a_msb != b_msb) && (r_msb != a_msb);
        else
            return (a_msb == b_msb) && (r_msb != a_msb);
    endfunction

endpackage

// File: rtl/alu_md_iter.sv
// Iterative shift-add multiplier / restoring divider working on operand
// magnitudes, with sign fixup folded into the final step.
module md_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_div,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic             last,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    localparam int CW = $clog2(WIDTH);

    logic             busy;
    logic [CW-1:0]    cnt;
    logic             div_m;
    logic             neg_q;
    logic             neg_r;
    logic             dz;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] dsr;

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   sum, trial, diff;
    logic [WIDTH-1:0] acc_n, lo_n;
    logic [2*WIDTH-1:0] prod, prod_f;
    logic [WIDTH-1:0] q_f, r_f;

    always_comb begin
        a_neg = is_signed & a[WIDTH-1];
        b_neg = is_signed & b[WIDTH-1];
        a_mag = a_neg ? -a : a;
        b_mag = b_neg ? -b : b;
    end

    // One iteration: mul consumes multiplier LSB first, div produces
    // quotient MSB first.  acc is the upper half / partial remainder.
    always_comb begin
        sum   = {1'b0, acc} + {1'b0, (lo_q[0] ? dsr : '0)};
        trial = {acc, lo_q[WIDTH-1]};
        diff  = trial - {1'b0, dsr};
        acc_n = sum[WIDTH:1];
        lo_n  = {sum[0], lo_q[WIDTH-1:1]};
        if (div_m) begin
            if (!diff[WIDTH]) begin
                acc_n = diff[WIDTH-1:0];
                lo_n  = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_n = trial[WIDTH-1:0];
                lo_n  = {lo_q[WIDTH-2:0], 1'b0};
            end
        end
    end

    // Divide by zero leaves the dividend magnitude in acc, so the remainder
    // fixup yields a; only the quotient needs overriding.
    always_comb begin
        prod   = {acc_n, lo_n};
        prod_f = neg_q ? -prod : prod;
        q_f    = dz ? '1 : (neg_q ? -lo_n : lo_n);
        r_f    = neg_r ? -acc_n : acc_n;
        hi_out = div_m ? r_f : prod_f[2*WIDTH-1:WIDTH];
        lo_out = div_m ? q_f : prod_f[WIDTH-1:0];
    end

    assign done = busy && (cnt == '0);
    assign last = busy && (cnt == CW'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy  <= 1'b0;
            cnt   <= '0;
            div_m <= 1'b0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            dz    <= 1'b0;
            acc   <= '0;
            lo_q  <= '0;
            dsr   <= '0;
        end else if (start) begin
            busy  <= 1'b1;
            cnt   <= CW'(WIDTH-1);
            div_m <= is_div;
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
            dz    <= (b == '0);
            acc   <= '0;
            lo_q  <= is_div ? a_mag : b_mag;
            dsr   <= is_div ? b_mag : a_mag;
        end else if (busy) begin
            acc <= acc_n;
            lo_q <= lo_n;
            cnt <= cnt - CW'(1);
            if (cnt == '0)
                busy <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_md.sv
// Execute-stage ALU: single-cycle ops plus an iterative mul/div unit that
// owns the architectural HI/LO registers and stalls via in_ready.
module alu_md
    import alu_md_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [SHW-1:0]   shamt,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_t state, state_nx;

    logic                    accept;
    logic                    is_mul_op, is_div_op, is_md_op, md_signed;
    logic signed [WIDTH-1:0] a_s, b_s;
    logic [WIDTH-1:0]        add_r, sub_r, simple_res;
    logic                    simple_ovf;

    logic [WIDTH-1:0] res_p1;
    logic             zero_p1, ovf_p1, vld_p1;
    logic [WIDTH-1:0] hi_q, lo_q;

    logic             md_done, md_last;
    logic [WIDTH-1:0] md_hi, md_lo;

    assign in_ready  = (state == IDLE);
    assign accept    = in_valid && in_ready;
    assign is_mul_op = (op == OP_MULT) || (op == OP_MULTU);
    assign is_div_op = (op == OP_DIV)  || (op == OP_DIVU);
    assign is_md_op  = is_mul_op || is_div_op;
    assign md_signed = (op == OP_MULT) || (op == OP_DIV);
    assign a_s       = a;
    assign b_s       = b;

    always_comb begin
        add_r      = a + b;
        sub_r      = a - b;
        simple_res = '0;
        simple_ovf = 1'b0;
        case (op)
            OP_ADD: begin
                simple_res = add_r;
                simple_ovf = addsub_ovf(1'b0, a[WIDTH-1], b[WIDTH-1], add_r[WIDTH-1]);
            end
            OP_SUB: begin
                simple_res = sub_r;
                simple_ovf = addsub_ovf(1'b1, a[WIDTH-1], b[WIDTH-1], sub_r[WIDTH-1]);
            end
            OP_OR:    simple_res = a | b;
            OP_AND:   simple_res = a & b;
            OP_SLT:   simple_res = WIDTH'(a_s < b_s);
            OP_NOR:   simple_res = ~(a | b);
            OP_SRL:   simple_res = b >> shamt;
            OP_PASSB: simple_res = b;
            OP_EQ:    simple_res = WIDTH'(a == b);
            OP_SLTU:  simple_res = WIDTH'(a < b);
            OP_XOR:   simple_res = a ^ b;
            OP_SLL:   simple_res = b << shamt;
            OP_SRA:   simple_res = b_s >>> shamt;
            OP_MFHI:  simple_res = hi_q;
            OP_MFLO:  simple_res = lo_q;
            OP_MTHI:  simple_res = a;
            OP_MTLO:  simple_res = a;
            default:  simple_res = '0;
        endcase
    end

    md_iter #(.WIDTH(WIDTH)) u_md_iter (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (accept && is_md_op),
        .is_div    (is_div_op),
        .is_signed (md_signed),
        .a         (a),
        .b         (b),
        .done      (md_done),
        .last      (md_last),
        .hi_out    (md_hi),
        .lo_out    (md_lo)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // FIX is the cycle the iterator performs its final step and sign fixup.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (accept && is_mul_op)
                    state_nx = MUL;
                else if (accept && is_div_op)
                    state_nx = DIV;
            end
            MUL, DIV: begin
                if (md_last)
                    state_nx = FIX;
            end
            FIX: begin
                if (md_done)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // ---- stage p1: registered result, flags and HI/LO ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_p1  <= '0;
            zero_p1 <= 1'b1;
            ovf_p1  <= 1'b0;
            vld_p1  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            vld_p1 <= 1'b0;
            if (state == FIX && md_done) begin
                hi_q    <= md_hi;
                lo_q    <= md_lo;
                res_p1  <= md_lo;
                zero_p1 <= (md_lo == '0);
                ovf_p1  <= 1'b0;
                vld_p1  <= 1'b1;
            end else if (accept && !is_md_op) begin
                res_p1  <= simple_res;
                zero_p1 <= (simple_res == '0);
                ovf_p1  <= simple_ovf;
                vld_p1  <= 1'b1;
                if (op == OP_MTHI)
                    hi_q <= a;
                if (op == OP_MTLO)
                    lo_q <= a;
            end
        end
    end

    assign out_valid = vld_p1;
    assign result    = res_p1;
    assign zero      = zero_p1;
    assign overflow  = ovf_p1;
    assign hi        = hi_q;
    assign lo        = lo_q;

endmodule
